// File: rtl/puf_ro_compare.sv
// puf_ro_compare: counts RO pair edges over a fixed clk window and emits a response bit plus tie flag
module puf_ro_compare #(
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             busy,
    output logic             resp_valid,
    output logic             resp_bit,
    output logic             resp_tie,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DECIDE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         a_sync_q, b_sync_q;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic               valid_q, valid_d, bit_q, bit_d, tie_q, tie_d;
    logic               edge_a, edge_b;

    // Two flops resynchronise each oscillator, the third gives the previous level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[1:0], ro_a};
            b_sync_q <= {b_sync_q[1:0], ro_b};
        end
    end

    assign edge_a = a_sync_q[1] & ~a_sync_q[2];
    assign edge_b = b_sync_q[1] & ~b_sync_q[2];

    // State, counters and held response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
            tie_q   <= tie_d;
        end
    end

    // Next state: clear on start, saturating count over the window, compare once, abort on ena low
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        valid_d = valid_q;
        bit_d   = bit_q;
        tie_d   = tie_q;
        case (state_q)
            IDLE: begin
                if (start && ena) begin
                    win_d   = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    valid_d = 1'b0;
                    bit_d   = 1'b0;
                    tie_d   = 1'b0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!ena) begin
                    state_d = IDLE;
                end else begin
                    cnt_a_d = (edge_a && !(&cnt_a_q)) ? cnt_a_q + CNT_W'(1) : cnt_a_q;
                    cnt_b_d = (edge_b && !(&cnt_b_q)) ? cnt_b_q + CNT_W'(1) : cnt_b_q;
                    win_d   = win_q + WIN_W'(1);
                    state_d = (win_q == WIN_LAST) ? DECIDE : COUNT;
                end
            end
            DECIDE: begin
                state_d = IDLE;
                if (ena) begin
                    bit_d   = cnt_a_q > cnt_b_q;
                    tie_d   = cnt_a_q == cnt_b_q;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = state_q != IDLE;
    assign resp_valid = valid_q;
    assign resp_bit   = bit_q;
    assign resp_tie   = tie_q;
    assign cnt_a      = cnt_a_q;
    assign cnt_b      = cnt_b_q;
endmodule
